alu_result_stage: RTL and testbench

- Registered output stage that sits directly downstream of the combinational 128-bit ALU.
- Captures each ALU result, its opcode and its carry/zero/sign flags into a small FIFO.
- Presents the captured entries to the writeback consumer over a valid/ready handshake.
- Decouples consumer backpressure from the ALU's combinational path and breaks the timing path.

---
 rtl/alu_result_stage.sv | 133 +++++++++++++
 tb/tb_alu_result_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered FIFO stage between the combinational ALU and
// the writeback consumer. Each accepted ALU result, opcode and flag set is
// buffered and presented to the consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        ALU-side handshake
//   in_opcode, in_result,
//   in_carry, in_zero, in_sign ALU entry captured on push
//   flush                      synchronous discard of all buffered entries
//   out_valid / out_ready      consumer-side handshake
//   out_opcode, out_result,
//   out_carry, out_zero,
//   out_sign                   head entry (forced to zero while empty)
//   level                      occupancy, 0..DEPTH
//   txn_count                  accepted (non-flushed) pushes since reset
module alu_result_stage #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_sign,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_sign,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             sign;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head_q, head_d;
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] txn_q;
  logic             push, pop;

  assign in_entry = '{opcode: in_opcode, result: in_result,
                      carry: in_carry, zero: in_zero, sign: in_sign};

  // Handshakes use registered ready/valid only; flush cancels both.
  assign push = in_valid && ready_q && !flush;
  assign pop  = valid_q && out_ready && !flush;

  // Next-state: pointers, level, and the head entry presented next cycle.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    head_d  = '0;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (!push && pop) level_d = level_q - LVL_W'(1);
    end
    // The slot being written this edge is not yet in mem, so bypass it
    // into the head register when it becomes the new head.
    if (level_d != '0) begin
      if (push && (rptr_d == wptr_q)) head_d = in_entry;
      else                            head_d = mem[rptr_d];
    end
    ready_d = (level_d != LVL_W'(DEPTH));
    valid_d = (level_d != '0);
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      head_q  <= '0;
      txn_q   <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      if (push) txn_q <= txn_q + CNT_W'(1);
    end
  end

  // Entry storage; contents are meaningful only between rptr and wptr.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in_entry;
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_opcode = head_q.opcode;
  assign out_result = head_q.result;
  assign out_carry  = head_q.carry;
  assign out_zero   = head_q.zero;
  assign out_sign   = head_q.sign;
  assign level      = level_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage (WIDTH=128, DEPTH=4, CNT_W=16).
module tb_alu_result_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [3:0]   in_opcode;
  logic [127:0] in_result;
  logic         in_carry, in_zero, in_sign;
  logic         flush;
  logic         out_valid, out_ready;
  logic [3:0]   out_opcode;
  logic [127:0] out_result;
  logic         out_carry, out_zero, out_sign;
  logic [2:0]   level;
  logic [15:0]  txn_count;

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;

  alu_result_stage #(.WIDTH(128), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_carry(in_carry), .in_zero(in_zero), .in_sign(in_sign),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_sign(out_sign),
    .level(level), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_opcode = 4'd0; in_result = '0;
    in_carry = 1'b0; in_zero = 1'b0; in_sign = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    exp_txn = 0;
  endtask

  task automatic drive_push(input logic [127:0] r);
    in_valid = 1'b1; in_result = r; in_opcode = r[3:0];
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL reset_txn got %0d exp 0", txn_count); end
    checks++; if (out_result !== 128'd0 || out_opcode !== 4'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_result); end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 4'd0; in_result = 128'h5;
    tick(); exp_txn++;
    idle(); out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_result !== 128'h5) begin errors++; $display("FAIL pass_head got v=%0b r=%h exp v=1 r=5", out_valid, out_result); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL pass_level1 got %0d exp 1", level); end
    tick();
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got l=%0d v=%0b exp 0 0", level, out_valid); end
    checks++; if (txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL pass_txn got %0d exp %0d", txn_count, exp_txn); end
    checks++; if (out_result !== 128'd0) begin errors++; $display("FAIL pass_empty_zero got %h exp 0", out_result); end
  endtask

  task automatic test_fill_backpressure();
    idle();
    for (int i = 1; i <= 4; i++) begin
      drive_push(128'(i)); tick(); exp_txn++;
    end
    checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got l=%0d rdy=%0b exp 4 0", level, in_ready); end
    // Offered while full, with undefined data: must be refused and harmless.
    in_valid = 1'b1; in_result = 'x; in_opcode = 'x;
    tick();
    checks++; if (level !== 3'd4 || txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL fill_reject got l=%0d t=%0d exp 4 %0d", level, txn_count, exp_txn); end
    idle(); out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== 128'(i)) begin errors++; $display("FAIL fill_order got v=%0b r=%0d exp 1 %0d", out_valid, out_result, i); end
      tick();
      if (i == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back got %0b exp 1", in_ready); end
      end
    end
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL fill_empty got v=%0b l=%0d exp 0 0", out_valid, level); end
  endtask

  task automatic test_full_with_pop();
    idle();
    for (int i = 11; i <= 14; i++) begin
      drive_push(128'(i)); tick(); exp_txn++;
    end
    drive_push(128'd99); out_ready = 1'b1;
    tick();
    idle();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL fullpop_level got %0d exp 3", level); end
    checks++; if (out_result !== 128'd12) begin errors++; $display("FAIL fullpop_head got %0d exp 12", out_result); end
    checks++; if (txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL fullpop_txn got %0d exp %0d", txn_count, exp_txn); end
    out_ready = 1'b1;
    for (int i = 12; i <= 14; i++) begin
      checks++; if (out_result !== 128'(i)) begin errors++; $display("FAIL fullpop_drain got %0d exp %0d", out_result, i); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_no99 got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_wrap();
    int np = 0;
    int nq = 0;
    int cyc = 0;
    logic [3:0] eop;
    do_reset();
    while (nq < 10 && cyc < 300) begin
      logic did_push, did_pop;
      in_valid = (np < 10);
      in_result = 128'(np); in_opcode = 4'(np % 11);
      in_carry = np[0]; in_zero = (np == 0); in_sign = np[1];
      out_ready = 1'($urandom_range(0, 1));
      did_push = in_valid && in_ready;
      did_pop = out_valid && out_ready;
      if (did_pop) begin
        eop = 4'(nq % 11);
        checks++;
        if (out_result !== 128'(nq) || out_opcode !== eop || out_carry !== nq[0] ||
            out_zero !== (nq == 0) || out_sign !== nq[1]) begin
          errors++;
          $display("FAIL wrap_entry got r=%0d op=%0d c%0b z%0b s%0b exp r=%0d op=%0d", out_result, out_opcode, out_carry, out_zero, out_sign, nq, eop);
        end
        nq++;
      end
      tick();
      if (did_push) begin np++; exp_txn++; end
      cyc++;
    end
    idle();
    checks++; if (nq != 10) begin errors++; $display("FAIL wrap_timeout got %0d pops exp 10", nq); end
    checks++; if (txn_count !== 16'd10 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_txn got t=%0d v=%0b exp 10 0", txn_count, out_valid); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 21; i <= 23; i++) begin
      drive_push(128'(i)); tick(); exp_txn++;
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", level); end
    drive_push(128'd77); out_ready = 1'b1; flush = 1'b1;
    tick();
    idle();
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got l=%0d v=%0b exp 0 0", level, out_valid); end
    checks++; if (out_result !== 128'd0) begin errors++; $display("FAIL flush_data got %h exp 0", out_result); end
    checks++; if (txn_count !== 16'(exp_txn) || in_ready !== 1'b1) begin errors++; $display("FAIL flush_txn got t=%0d rdy=%0b exp %0d 1", txn_count, in_ready, exp_txn); end
  endtask

  task automatic test_async_reset();
    idle();
    drive_push(128'd31); tick();
    drive_push(128'd32); tick();
    idle();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL arst_pre got %0d exp 2", level); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 3'd0 || out_result !== 128'd0) begin errors++; $display("FAIL arst_immediate got v=%0b l=%0d exp 0 0", out_valid, level); end
    tick();
    rst_n = 1'b1;
    tick();
    exp_txn = 0;
    in_valid = 1'b1; in_result = '1; in_opcode = 4'd3; in_sign = 1'b1;
    tick(); exp_txn++;
    idle();
    checks++; if (out_valid !== 1'b1 || out_sign !== 1'b1 || out_result !== {128{1'b1}}) begin errors++; $display("FAIL arst_first got v=%0b s=%0b r=%h exp 1 1 all-ones", out_valid, out_sign, out_result); end
    checks++; if (txn_count !== 16'(exp_txn)) begin errors++; $display("FAIL arst_txn got %0d exp 1", txn_count); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fill_backpressure();
    test_full_with_pop();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
